pixel_stream_tx: RTL and testbench

Frame transmitter that drives the raw-pixel input of the visual-odometry chip (FAST → BRIEF → MATCH pipeline). It accepts pixels from a host over a valid/ready handshake into a small FIFO. Once the chip is ready and the FIFO is prefilled, it emits one `o_start` pulse and then exactly WIDTH×HEIGHT pixels on consecutive cycles, in raster order. The chip's pixel input has no valid qualifier, so gap-free streaming and underrun detection are this block's job.

---
 rtl/pixel_stream_tx_if.sv | 27 ++
 rtl/pixel_stream_tx.sv | 140 ++++++++++++++
 tb/tb_pixel_stream_tx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_tx_if.sv
// Bundle between the frame transmitter, its pixel host and the visual-odometry chip.
// Handshake: a host pixel moves on every rising clock edge where i_in_valid and o_in_ready are both 1;
// the host holds i_in_data stable while i_in_valid is high, and o_in_ready never depends on i_in_valid.
interface pixel_stream_tx_if;
  logic       i_frame_go;
  logic       i_in_valid;
  logic [7:0] i_in_data;
  logic       o_in_ready;
  logic       i_chip_ready;
  logic [7:0] o_pixel;
  logic       o_start;
  logic       o_pix_valid;
  logic       o_last;
  logic       o_busy;
  logic       o_underrun;
  logic [2:0] dbg_state;

  modport slave (
    input  i_frame_go, i_in_valid, i_in_data, i_chip_ready,
    output o_in_ready, o_pixel, o_start, o_pix_valid, o_last, o_busy, o_underrun, dbg_state
  );

  modport master (
    output i_frame_go, i_in_valid, i_in_data, i_chip_ready,
    input  o_in_ready, o_pixel, o_start, o_pix_valid, o_last, o_busy, o_underrun, dbg_state
  );
endinterface

// File: rtl/pixel_stream_tx.sv
// Frame transmitter: buffers host pixels in a small FIFO and streams one gap-free raster frame
// to the chip after a single start pulse, flagging any FIFO underrun.
module pixel_stream_tx #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int PREFILL    = 16
) (
  input logic              i_clk,
  input logic              i_rst,
  pixel_stream_tx_if.slave bus
);

  localparam int FRAME  = WIDTH * HEIGHT;
  localparam int THRESH = (FRAME < PREFILL) ? FRAME : PREFILL;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int XW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int NW     = $clog2(FRAME + 1);

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
  localparam logic [NW-1:0] FRAME_C  = NW'(FRAME);
  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_RDY = 3'd1;
  localparam logic [2:0] S_PREFILL  = 3'd2;
  localparam logic [2:0] S_START    = 3'd3;
  localparam logic [2:0] S_STREAM   = 3'd4;

  logic [2:0]    state, state_nx;
  logic [CW-1:0] count, count_nx;
  logic [NW-1:0] acc, acc_nx;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [7:0]    mem [FIFO_DEPTH];

  logic       in_ready_q, busy_q, start_q, pix_valid_q, last_q, underrun_q;
  logic [7:0] pixel_q;

  logic push, go, stream_pop, fifo_pop, is_last;

  assign push    = bus.i_in_valid & in_ready_q;
  assign go      = (state == S_IDLE) & bus.i_frame_go;
  assign is_last = (x == X_LAST) & (y == Y_LAST);

  // Registered outputs run one cycle ahead of the state: a pixel leaves the FIFO on the edge
  // entering each STREAM cycle, so it is visible during that cycle and o_start leads it by one.
  assign stream_pop = (state == S_START) | ((state == S_STREAM) & ~last_q);
  assign fifo_pop   = stream_pop & (count != '0);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (bus.i_frame_go) state_nx = S_WAIT_RDY;
      S_WAIT_RDY: if (bus.i_chip_ready) state_nx = S_PREFILL;
      S_PREFILL:  if (count >= THRESH_C) state_nx = S_START;
      S_START:    state_nx = S_STREAM;
      S_STREAM:   if (last_q) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    count_nx = count + CW'(push) - CW'(fifo_pop);
    acc_nx   = acc;
    if (go) begin
      acc_nx = '0;
    end else if (push && (acc < FRAME_C)) begin
      acc_nx = acc + NW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= bus.i_in_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      count       <= '0;
      acc         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      x           <= '0;
      y           <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      pix_valid_q <= 1'b0;
      last_q      <= 1'b0;
      underrun_q  <= 1'b0;
      pixel_q     <= 8'h00;
    end else begin
      state       <= state_nx;
      count       <= count_nx;
      acc         <= acc_nx;
      busy_q      <= (state_nx != S_IDLE);
      start_q     <= (state_nx == S_START);
      pix_valid_q <= stream_pop;
      last_q      <= stream_pop & is_last;
      in_ready_q  <= (state_nx != S_IDLE) & (count_nx < DEPTH_C) & (acc_nx < FRAME_C);
      if (push)     wr_ptr <= wr_ptr + AW'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + AW'(1);

      if (go) begin
        x          <= '0;
        y          <= '0;
        underrun_q <= 1'b0;
      end else if (stream_pop) begin
        // An empty FIFO still consumes a pixel slot; the frame length never stretches.
        pixel_q <= fifo_pop ? mem[rd_ptr] : 8'h00;
        if (!fifo_pop) underrun_q <= 1'b1;
        if (is_last) begin
          x <= '0;
          y <= '0;
        end else if (x == X_LAST) begin
          x <= '0;
          y <= y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

  assign bus.o_in_ready  = in_ready_q;
  assign bus.o_pixel     = pixel_q;
  assign bus.o_start     = start_q;
  assign bus.o_pix_valid = pix_valid_q;
  assign bus.o_last      = last_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_underrun  = underrun_q;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed bench for pixel_stream_tx (4x2 frame, 4-entry FIFO, prefill 4) with an expected-pixel queue.
module tb_pixel_stream_tx;

  localparam int FRAME = 8;

  logic clk;
  logic rst;

  pixel_stream_tx_if bus ();

  pixel_stream_tx #(
    .WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(4), .PREFILL(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] host_q[$];
  bit         host_en;

  int cyc, pix_cnt, start_cnt, start_cyc, first_cyc, last_cyc, acc_cnt;
  bit last_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    pix_cnt   = 0;
    start_cnt = 0;
    start_cyc = -1;
    first_cyc = -1;
    last_cyc  = -1;
    last_seen = 0;
  endtask

  // One clock: drive host, cross the edge, then account transfers and check outputs.
  task automatic tick();
    bit         xfer;
    logic [7:0] e;
    bus.i_in_valid = host_en && (host_q.size() != 0);
    bus.i_in_data  = (host_q.size() != 0) ? host_q[0] : 8'h00;
    xfer = bus.i_in_valid && bus.o_in_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (xfer) begin
      void'(host_q.pop_front());
      acc_cnt++;
      if (acc_cnt == FRAME) check("ready_after_full_frame", bus.o_in_ready, 1'b0);
    end
    if (bus.o_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (bus.o_pix_valid) begin
      if (pix_cnt == 0) first_cyc = cyc;
      last_cyc = cyc;
      pix_cnt++;
      check("exp_available", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pixel", bus.o_pixel, e);
      end
    end
    if (bus.o_last) begin
      last_seen = 1;
      check("last_index", pix_cnt, FRAME);
      check("last_with_valid", bus.o_pix_valid, 1'b1);
    end
  endtask

  task automatic pulse_go();
    acc_cnt = 0;
    bus.i_frame_go = 1'b1;
    tick();
    bus.i_frame_go = 1'b0;
  endtask

  task automatic wait_last(input string tag);
    for (int i = 0; i < 60 && !last_seen; i++) tick();
    check(tag, last_seen, 1'b1);
  endtask

  task automatic load_frame(input logic [7:0] base, input int n_host);
    for (int i = 0; i < n_host; i++) host_q.push_back(base + 8'(i));
  endtask

  task automatic check_frame_shape(input string tag);
    check({tag, "_starts"}, start_cnt, 1);
    check({tag, "_pixels"}, pix_cnt, FRAME);
    check({tag, "_start_lead"}, first_cyc - start_cyc, 1);
    check({tag, "_contiguous"}, last_cyc - first_cyc, FRAME - 1);
    check({tag, "_exp_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    cyc              = 0;
    acc_cnt          = 0;
    host_en          = 1'b1;
    rst              = 1'b1;
    bus.i_frame_go   = 1'b0;
    bus.i_in_valid   = 1'b0;
    bus.i_in_data    = 8'h00;
    bus.i_chip_ready = 1'b0;
    clear_stats();

    // Reset state
    tick();
    tick();
    check("rst_pixel", bus.o_pixel, 8'h00);
    check("rst_start", bus.o_start, 1'b0);
    check("rst_pix_valid", bus.o_pix_valid, 1'b0);
    check("rst_last", bus.o_last, 1'b0);
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_in_ready", bus.o_in_ready, 1'b0);
    check("rst_underrun", bus.o_underrun, 1'b0);
    check("rst_state", bus.dbg_state, 3'd0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", bus.o_in_ready, 1'b0);
    check("idle_busy", bus.o_busy, 1'b0);

    // Nominal frame
    bus.i_chip_ready = 1'b1;
    load_frame(8'h10, 8);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h10 + 8'(i));
    clear_stats();
    pulse_go();
    check("nom_busy_after_go", bus.o_busy, 1'b1);
    wait_last("nom_last_timeout");
    check_frame_shape("nom");
    check("nom_underrun", bus.o_underrun, 1'b0);
    tick();
    tick();
    check("nom_pixel_hold", bus.o_pixel, 8'h17);
    check("nom_idle_busy", bus.o_busy, 1'b0);
    check("nom_host_drained", host_q.size(), 0);

    // Chip not ready
    bus.i_chip_ready = 1'b0;
    load_frame(8'h20, 8);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h20 + 8'(i));
    clear_stats();
    pulse_go();
    for (int i = 0; i < 20; i++) tick();
    check("nrdy_no_start", start_cnt, 0);
    check("nrdy_fifo_fill", host_q.size(), 4);
    check("nrdy_in_ready", bus.o_in_ready, 1'b0);
    check("nrdy_state", bus.dbg_state, 3'd1);
    bus.i_chip_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (start_cnt == 0 && n < 6) begin
        tick();
        n++;
      end
      check("nrdy_start_latency_ok", (start_cnt == 1) && (n <= 2), 1'b1);
    end
    wait_last("nrdy_last_timeout");
    check_frame_shape("nrdy");
    check("nrdy_underrun", bus.o_underrun, 1'b0);
    tick();

    // Underrun: host only ever supplies five pixels
    load_frame(8'h30, 5);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h30 + 8'(i));
    for (int i = 0; i < 3; i++) exp_q.push_back(8'h00);
    clear_stats();
    pulse_go();
    wait_last("urun_last_timeout");
    check_frame_shape("urun");
    check("urun_flag", bus.o_underrun, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    check("urun_sticky", bus.o_underrun, 1'b1);

    // Overflow guard: twelve offered, eight accepted
    load_frame(8'h40, 12);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h40 + 8'(i));
    clear_stats();
    pulse_go();
    check("ovf_underrun_cleared", bus.o_underrun, 1'b0);
    wait_last("ovf_last_timeout");
    check_frame_shape("ovf");
    tick();
    tick();
    check("ovf_accepted", acc_cnt, FRAME);
    check("ovf_left_with_host", host_q.size(), 4);
    check("ovf_idle_in_ready", bus.o_in_ready, 1'b0);
    host_q.delete();

    // Back-to-back frames
    load_frame(8'h50, 8);
    load_frame(8'h60, 8);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h50 + 8'(i));
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h60 + 8'(i));
    clear_stats();
    pulse_go();
    wait_last("b2b_a_last_timeout");
    check("b2b_a_pixels", pix_cnt, FRAME);
    tick();
    check("b2b_gap_busy", bus.o_busy, 1'b0);
    clear_stats();
    pulse_go();
    check("b2b_b_busy", bus.o_busy, 1'b1);
    wait_last("b2b_b_last_timeout");
    check_frame_shape("b2b_b");
    check("b2b_underrun", bus.o_underrun, 1'b0);
    tick();

    // Reset during the third pixel
    load_frame(8'h70, 8);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h70 + 8'(i));
    clear_stats();
    pulse_go();
    for (int i = 0; i < 30 && pix_cnt < 3; i++) tick();
    check("mrst_reached_pixel3", pix_cnt, 3);
    rst = 1'b1;
    #1;
    check("mrst_pixel", bus.o_pixel, 8'h00);
    check("mrst_start", bus.o_start, 1'b0);
    check("mrst_pix_valid", bus.o_pix_valid, 1'b0);
    check("mrst_last", bus.o_last, 1'b0);
    check("mrst_busy", bus.o_busy, 1'b0);
    check("mrst_in_ready", bus.o_in_ready, 1'b0);
    check("mrst_state", bus.dbg_state, 3'd0);
    exp_q.delete();
    host_q.delete();
    tick();
    tick();
    rst = 1'b0;
    load_frame(8'h80, 8);
    clear_stats();
    for (int i = 0; i < 10; i++) tick();
    check("mrst_no_start", start_cnt, 0);
    check("mrst_no_pixels", pix_cnt, 0);
    check("mrst_no_accept", host_q.size(), 8);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h80 + 8'(i));
    pulse_go();
    wait_last("mrst_last_timeout");
    check_frame_shape("mrst");
    check("mrst_underrun", bus.o_underrun, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
